// File: rtl/fetch_log_checker.sv
// rtl/fetch_log_checker.sv - in-order fetch log with RVFI retirement checking
// Optional immediate assertions are compiled in with FETCH_LOG_FORMAL_EN.
module fetch_log_checker #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     mem_valid_i,
  input  logic                     mem_instr_i,
  input  logic                     mem_ready_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     rvfi_valid_i,
  input  logic [31:0]              rvfi_pre_pc_i,
  input  logic [31:0]              rvfi_insn_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o,
  output logic [2:0]               err_code_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ADDR  = 3'd1;
  localparam logic [2:0] ERR_DATA  = 3'd2;
  localparam logic [2:0] ERR_UNDER = 3'd3;
  localparam logic [2:0] ERR_OVER  = 3'd4;

  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [2:0]    err_code_q, err_code_d;

  logic          push, pop, empty, full, do_push, do_pop, err_next;
  logic [2:0]    cause;

  always_comb begin
    push  = mem_valid_i && mem_ready_i && mem_instr_i;
    pop   = rvfi_valid_i;
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);

    // A flushed cycle neither moves the log nor is checked.
    do_pop  = pop && !empty && !flush_i;
    do_push = push && !flush_i && (!full || do_pop);

    cause = ERR_NONE;
    if (pop && empty) begin
      cause = ERR_UNDER;
    end else if (pop && (addr_mem[rd_ptr_q] != rvfi_pre_pc_i)) begin
      cause = ERR_ADDR;
    end else if (pop && (data_mem[rd_ptr_q] != rvfi_insn_i)) begin
      cause = ERR_DATA;
    end else if (push && full && !pop) begin
      cause = ERR_OVER;
    end
    err_next = (cause != ERR_NONE) && !flush_i;

    wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(do_push) - CW'(do_pop);
    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_next && !err_q) begin
      err_d      = 1'b1;
      err_code_d = cause;
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Storage is not reset; it is only read while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) begin
      addr_mem[wr_ptr_q] <= mem_addr_i;
      data_mem[wr_ptr_q] <= mem_rdata_i;
    end
  end

`ifdef FETCH_LOG_FORMAL_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!err_next);
      assert (count_q <= FULL_CNT);
    end
  end
`else
  // Errors surface only through err_o / err_code_o.
`endif

  assign count_o    = count_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_fetch_log_checker.sv
// tb/tb_fetch_log_checker.sv - randomized and directed checks against a queue model
module tb_fetch_log_checker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, mem_valid, mem_instr, mem_ready, rvfi_valid;
  logic [31:0] mem_addr, mem_rdata, rvfi_pre_pc, rvfi_insn;
  logic [2:0]  count;
  logic        err;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] mq[$];
  logic        m_err;
  logic [2:0]  m_code;

  always #5 clk = ~clk;

  fetch_log_checker #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_instr_i(mem_instr), .mem_ready_i(mem_ready),
    .mem_addr_i(mem_addr), .mem_rdata_i(mem_rdata),
    .rvfi_valid_i(rvfi_valid), .rvfi_pre_pc_i(rvfi_pre_pc), .rvfi_insn_i(rvfi_insn),
    .count_o(count), .err_o(err), .err_code_o(err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_step(input bit push, input logic [31:0] a, input logic [31:0] d,
                            input bit pop, input logic [31:0] pc, input logic [31:0] insn,
                            input bit fl);
    int          size0;
    logic [2:0]  cause;
    logic [63:0] head;
    cause = 3'd0;
    size0 = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) begin
        if (size0 == 0) cause = 3'd3;
        else begin
          head = mq.pop_front();
          if (head[63:32] != pc)      cause = 3'd1;
          else if (head[31:0] != insn) cause = 3'd2;
        end
      end
      if (push) begin
        if (size0 == DEPTH && !pop) begin
          if (cause == 3'd0) cause = 3'd4;
        end else mq.push_back({a, d});
      end
    end
    if (cause != 3'd0 && !m_err) begin
      m_err  = 1'b1;
      m_code = cause;
    end
  endtask

  task automatic step(input bit push, input logic [31:0] a, input logic [31:0] d,
                      input bit pop, input logic [31:0] pc, input logic [31:0] insn,
                      input bit fl);
    @(negedge clk);
    if (push) begin
      mem_valid = 1'b1; mem_ready = 1'b1; mem_instr = 1'b1;
    end else begin
      // Non-fetch bus noise that must never be logged.
      mem_valid = 1'($urandom); mem_ready = 1'($urandom); mem_instr = 1'b0;
    end
    mem_addr = a; mem_rdata = d;
    rvfi_valid = pop; rvfi_pre_pc = pc; rvfi_insn = insn;
    flush = fl;
    model_step(push, a, d, pop, pc, insn, fl);
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(mq.size()));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
  endtask

  task automatic idle();
    step(0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_valid = 1'b1; mem_ready = 1'b1; mem_instr = 1'b1;
    rvfi_valid = 1'b1; flush = 1'b0;
    mem_addr = $urandom; mem_rdata = $urandom;
    @(posedge clk);
    #1;
    mq.delete();
    m_err = 1'b0;
    m_code = 3'd0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_valid = 1'b0; rvfi_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, pc, insn;
    bit          push, pop, fl;
    reset = 1'b1; flush = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_ready = 1'b0;
    rvfi_valid = 1'b0; mem_addr = '0; mem_rdata = '0; rvfi_pre_pc = '0; rvfi_insn = '0;
    m_err = 1'b0; m_code = 3'd0;

    // Basic fetch then matching retire.
    do_reset();
    step(1, 32'h100, 32'h13, 0, 0, 0, 0);
    check("t1_count1", 32'(count), 32'd1);
    step(0, 0, 0, 1, 32'h100, 32'h13, 0);
    check("t1_count0", 32'(count), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // Address mismatch, then later data mismatch must not override the code.
    do_reset();
    step(1, 32'h100, 32'h13, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h104, 32'h13, 0);
    check("t2_err", 32'(err), 32'd1);
    check("t2_code", 32'(err_code), 32'd1);
    step(1, 32'h108, 32'hAAAA_0001, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h108, 32'hBBBB_0002, 0);
    check("t2_code_sticky", 32'(err_code), 32'd1);

    // Underflow with a simultaneous push: push is still stored.
    do_reset();
    step(1, 32'h200, 32'h33, 1, 32'h200, 32'h33, 0);
    check("t3_code", 32'(err_code), 32'd3);
    check("t3_count", 32'(count), 32'd1);

    // Overflow on the fifth push.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0, 0, 0);
    check("t4_code", 32'(err_code), 32'd4);
    check("t4_count", 32'(count), 32'd4);
    step(0, 0, 0, 1, 32'h300, 32'h1000, 0);
    step(0, 0, 0, 1, 32'h304, 32'h1001, 0);
    step(0, 0, 0, 1, 32'h308, 32'h1002, 0);
    step(0, 0, 0, 1, 32'h30C, 32'h1003, 0);
    check("t4_drained", 32'(count), 32'd0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(4 * i), 32'h2000 + 32'(i), 0, 0, 0, 0);
    step(1, 32'h410, 32'h2004, 1, 32'h400, 32'h2000, 0);
    check("t4b_count", 32'(count), 32'd4);
    check("t4b_err", 32'(err), 32'd0);
    for (int i = 1; i < 5; i++) step(0, 0, 0, 1, 32'h400 + 32'(4 * i), 32'h2000 + 32'(i), 0);
    check("t4b_err_after", 32'(err), 32'd0);

    // Flush discards a bad retirement in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(4 * i), 32'h3000 + 32'(i), 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h500, 32'hDEAD_BEEF, 1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_err", 32'(err), 32'd0);

    // 20 pairs with 0..3 idle cycles between fetch and retire.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h600 + 32'(4 * i), 32'h4000 + 32'(i * 7), 0, 0, 0, 0);
      for (int g = 0; g < (i % 4); g++) idle();
      step(0, 0, 0, 1, 32'h600 + 32'(4 * i), 32'h4000 + 32'(i * 7), 0);
    end
    check("t6_count", 32'(count), 32'd0);
    check("t6_err", 32'(err), 32'd0);

    // Random traffic: mostly correct retirements with rare corruption and flushes.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        push = ($urandom_range(0, 2) != 0);
        a    = {$urandom, 2'b00} >> 2 << 2;
        d    = $urandom;
        if (mq.size() > 0) begin
          pop  = 1'($urandom);
          pc   = mq[0][63:32];
          insn = mq[0][31:0];
        end else begin
          pop  = ($urandom_range(0, 15) == 0);
          pc   = $urandom;
          insn = $urandom;
        end
        if ($urandom_range(0, 40) == 0) pc = pc ^ 32'h4;
        if ($urandom_range(0, 40) == 0) insn = insn ^ 32'h1;
        fl = ($urandom_range(0, 30) == 0);
        step(push, a, d, pop, pc, insn, fl);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
